// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one unified memory between fetch and data ports,
// with programmable access latency and a halt/dump/park sequence.
module mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ready,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    input  logic        halt,
    output logic        halted,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic        mem_createdump,
    input  logic [15:0] mem_data_out
);
    typedef enum logic [2:0] {IDLE, BUSY, RESP, DUMP, HALTED} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic gnt, last_gnt;
    logic [15:0] lat_addr, lat_wdata;
    logic lat_wr, grant_d, take, busy;
    // gnt/last_gnt: 1 = data port, 0 = fetch port
    always_comb begin
        grant_d = d_req && (!if_req || !last_gnt);
        take = state == IDLE && !halt && (if_req || d_req);
        state_nx = state;
        case (state)
            IDLE:    state_nx = halt ? DUMP : take ? BUSY : IDLE;
            BUSY:    state_nx = cnt == '0 ? RESP : BUSY;
            RESP:    state_nx = IDLE;
            DUMP:    state_nx = HALTED;
            default: state_nx = HALTED;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            gnt <= 1'b0;
            last_gnt <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            lat_wr <= 1'b0;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                gnt <= grant_d;
                last_gnt <= grant_d;
                lat_addr <= grant_d ? d_addr : if_addr;
                lat_wdata <= grant_d ? d_wdata : '0;
                lat_wr <= grant_d && d_wr;
                cnt <= CNT_W'(MEM_LAT - 1);
            end
            if (busy && cnt != '0)
                cnt <= cnt - 1'b1;
            if (busy && cnt == '0 && !lat_wr) begin
                if (gnt)
                    d_rdata <= mem_data_out;
                else
                    if_rdata <= mem_data_out;
            end
        end
    end
    assign busy = state == BUSY;
    assign mem_enable = busy;
    assign mem_addr = busy ? lat_addr : '0;
    assign mem_data_in = busy ? lat_wdata : '0;
    assign mem_wr = busy && lat_wr;
    assign mem_createdump = state == DUMP;
    assign halted = state == HALTED;
    assign if_ready = state == RESP && !gnt;
    assign d_ready = state == RESP && gnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a ready-driven scoreboard against a behavioural memory.
module tb_mem_arbiter;
    localparam int LAT = 3;
    logic clk = 1'b0, rst = 1'b0;
    logic if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, halt = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic if_ready, d_ready, halted, mem_enable, mem_wr, mem_createdump;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
    logic [15:0] mem [0:65535];

    typedef struct {bit d; logic [15:0] data; int cyc;} exp_t;
    exp_t q[$];
    exp_t e;
    int vectors = 0, miscompares = 0;
    int cyc = 0, en_cnt = 0, wr_cnt = 0, dump_cnt = 0;

    mem_arbiter #(.MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .halt(halt), .halted(halted),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable),
        .mem_wr(mem_wr), .mem_createdump(mem_createdump), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_enable && mem_wr)
            mem[mem_addr] = mem_data_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: every ready pulse pops one expectation
    always @(negedge clk) begin
        if (mem_enable) en_cnt++;
        if (mem_wr) wr_cnt++;
        if (mem_createdump) dump_cnt++;
        if (if_ready && d_ready)
            chk("dual_ready", 1, 0);
        else if (if_ready || d_ready) begin
            if (q.size() == 0)
                chk("unexpected_ready", {30'd0, d_ready, if_ready}, 0);
            else begin
                e = q.pop_front();
                chk("ready_port", {31'd0, d_ready}, {31'd0, e.d});
                chk("rdata", {16'd0, d_ready ? d_rdata : if_rdata}, {16'd0, e.data});
                if (e.cyc >= 0)
                    chk("ready_cycle", cyc, e.cyc);
            end
        end
    end

    // called at a negedge where the DUT is idle; returns at the following idle negedge
    task automatic access(input bit d, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_data);
        bit got = 0;
        q.push_back('{d, exp_data, cyc + LAT + 1});
        if (d) begin
            d_addr = addr; d_wr = wr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = d ? d_ready : if_ready;
        end
        if (!got) chk("access_timeout", 0, 1);
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_strobes"}, {26'd0, if_ready, d_ready, halted, mem_enable, mem_wr, mem_createdump}, 0);
        chk({nm, "_addr_data"}, {mem_addr, mem_data_in}, 0);
        chk({nm, "_rdata"}, {if_rdata, d_rdata}, 0);
    endtask

    initial begin
        int k, left_d, left_i;
        bit got;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 16'hABCD;
        mem[16'h0100] = 16'h1111;
        mem[16'h0300] = 16'h3333;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        en_cnt = 0;
        access(0, 0, 16'h0010, 16'h0000, 16'hABCD);
        chk("fetch_enable_cycles", en_cnt, LAT);
        wr_cnt = 0;
        access(1, 1, 16'h0200, 16'h1234, 16'h0000);
        chk("write_strobe_cycles", wr_cnt, LAT);
        chk("write_mem_content", {16'd0, mem[16'h0200]}, 32'h1234);
        access(1, 0, 16'h0200, 16'h0000, 16'h1234);
        access(1, 0, 16'h0300, 16'h0000, 16'h3333);

        // reset during an access: outputs clear at once, no ready follows
        if_addr = 16'h0100; if_req = 1'b1;
        @(negedge clk);
        chk("busy_enable", {31'd0, mem_enable}, 1);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        if_req = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // both held: data wins first after reset, then strict alternation
        k = cyc;
        for (int i = 0; i < 6; i++)
            q.push_back('{(i % 2) == 0, (i % 2) == 0 ? 16'h3333 : 16'h1111, k + LAT + 1 + i * (LAT + 2)});
        if_addr = 16'h0100; d_addr = 16'h0300; d_wr = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        left_d = 3; left_i = 3;
        for (int i = 0; i < 200 && (left_d > 0 || left_i > 0); i++) begin
            @(negedge clk);
            if (d_ready) begin d_req = 1'b0; left_d--; end
            else if (!d_req && left_d > 0) d_req = 1'b1;
            if (if_ready) begin if_req = 1'b0; left_i--; end
            else if (!if_req && left_i > 0) if_req = 1'b1;
        end
        chk("alternation_done", {left_d[15:0], left_i[15:0]}, 0);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // halt raised mid-fetch: fetch completes, then one dump, then parked
        q.push_back('{0, 16'hABCD, cyc + LAT + 1});
        if_addr = 16'h0010; if_req = 1'b1;
        @(negedge clk);
        halt = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = if_ready;
        end
        chk("halt_fetch_done", {31'd0, got}, 1);
        if_req = 1'b0;
        dump_cnt = 0;
        @(negedge clk);
        chk("idle_before_dump", {30'd0, mem_createdump, halted}, 0);
        @(negedge clk);
        chk("dump_pulse", {30'd0, mem_createdump, mem_enable}, 32'h2);
        @(negedge clk);
        chk("halted_after_dump", {30'd0, halted, mem_createdump}, 32'h2);
        en_cnt = 0;
        if_req = 1'b1; d_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("halted_ignores_req", en_cnt, 0);
        chk("single_dump", dump_cnt, 1);
        if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
        repeat (3) @(negedge clk);
        chk("halted_sticky", {31'd0, halted}, 1);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("halted_cleared", {31'd0, halted}, 0);
        rst = 1'b1;
        @(negedge clk);

        // halt beats simultaneous requests in idle
        en_cnt = 0;
        halt = 1'b1; if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk("idle_halt_dump", {30'd0, mem_createdump, mem_enable}, 32'h2);
        @(negedge clk);
        chk("idle_halt_parked", {30'd0, halted, mem_createdump}, 32'h2);
        repeat (10) @(negedge clk);
        chk("idle_halt_no_enable", en_cnt, 0);
        if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
        @(negedge clk);

        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single 16-bit unified memory (memory2c-style) between the instruction-fetch port and the data-access port of the single-cycle core.
- Arbitrates round-robin and holds each access for a configurable memory latency.
- Returns a one-cycle ready pulse with registered read data.
- On halt, drains any in-flight access, issues the one-cycle createdump to memory, then parks.

Parameters:
- MEM_LAT, 1, number of cycles mem_enable is held per access; legal range 1..15.
- CNT_W, 4, width of the latency down-counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- if_req  input  1  fetch read request, held until if_ready.
- if_addr  input  16  fetch address, stable while if_req is high.
- if_ready  output  1  one-cycle completion pulse for fetch.
- if_rdata  output  16  fetch read data; valid when if_ready=1, held until the next fetch completion.
- d_req  input  1  data request, held until d_ready.
- d_wr  input  1  1=write, 0=read; stable while d_req is high.
- d_addr  input  16  data address.
- d_wdata  input  16  write data.
- d_ready  output  1  one-cycle completion pulse for data.
- d_rdata  output  16  data read data; valid when d_ready=1, held until the next data read completion.
- halt  input  1  level; requests dump and stop.
- halted  output  1  high once dump is issued; sticky until reset.
- mem_addr  output  16  memory address.
- mem_data_in  output  16  memory write data.
- mem_enable  output  1  memory enable.
- mem_wr  output  1  memory write strobe.
- mem_createdump  output  1  memory dump strobe.
- mem_data_out  input  16  memory read data, combinational from mem_addr.

Behaviour:
- States: IDLE, BUSY, RESP, DUMP, HALTED. All outputs are registered or pure decodes of state plus latched registers.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, last_gnt=IF, all latched address/data/rdata registers=0, every output=0. An in-flight access is abandoned and no ready pulse is issued.
- IDLE:
  - If halt=1 → DUMP. Halt takes priority over any pending request.
  - Else if exactly one req is high → grant that port.
  - If both are high → grant the port not equal to last_gnt. Since last_gnt resets to IF, data wins the first conflict.
  - On grant: latch addr, wdata and wr (wr is forced 0 for fetch), set gnt and last_gnt, cnt=MEM_LAT-1, go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_enable=1; mem_addr, mem_data_in and mem_wr are driven from the latched values.
  - cnt decrements each cycle.
  - When cnt=0: capture mem_data_out into the granted port's rdata register (reads only; writes leave it unchanged), go to RESP.
  - A write may strobe memory MEM_LAT times with identical data; this is intended.
- RESP:
  - mem_enable=0; exactly one of if_ready/d_ready=1 for the granted port.
  - Next state is IDLE unconditionally.
  - The requester deasserts req in the cycle after the pulse, so the stale req is never re-granted.
- Latency: request first seen in IDLE cycle T → BUSY in cycles T+1..T+MEM_LAT → ready in cycle T+MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Halt asserted during BUSY/RESP: the current access completes normally, including its ready pulse. The next IDLE cycle takes DUMP.
- DUMP: exactly one cycle with mem_createdump=1 and mem_enable=0, then HALTED.
- HALTED: halted=1, all mem strobes 0, requests ignored. The only exit is reset.
- Both requests held continuously → strict alternation, no starvation. Worst-case wait is one foreign access.
- Address and data pass through unmodified; there is no width conversion and no address wrap logic.

Test Plan:
- Single fetch, MEM_LAT=1: if_addr=0x0010, memory holds 0xABCD → mem_enable high 1 cycle; if_ready pulses in cycle T+2; if_rdata=0xABCD.
- Data write then read, MEM_LAT=3:
  - Write d_addr=0x0200, d_wdata=0x1234 → mem_wr high 3 cycles; d_ready at T+4; d_rdata unchanged.
  - Then read 0x0200 → d_rdata=0x1234.
- Both requests held for 6 accesses → grant order D,IF,D,IF,D,IF; each ready pulse is 1 cycle; no double grant.
- Halt during a BUSY fetch, MEM_LAT=2 → fetch completes with if_ready; then mem_createdump high exactly 1 cycle; halted=1; later if_req/d_req get no ready.
- Reset asserted mid-BUSY → all outputs 0 immediately, no ready pulse. After release, the first conflict grants data.
- Halt with simultaneous requests in IDLE → DUMP taken; mem_enable never asserted; halted=1 after 1 cycle.
